iq_dispatch: RTL and testbench



---
 rtl/tomasula_types.sv | 26 ++
 rtl/iq_dispatch_if.sv | 22 ++
 rtl/iq_dispatch_rr_pick.sv | 17 +
 rtl/iq_dispatch.sv | 66 ++++++
 tb/tb_iq_dispatch.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/tomasula_types.sv
// tomasula_types: shared control-word, op encoding and destination rule
package tomasula_types;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_SLL = 4'h5,
    OP_SRL = 4'h6,
    BRANCH = 4'h7,
    OP_ST  = 4'h8,
    OP_NOP = 4'h9
  } op_t;
  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } ctl_word;
  localparam ctl_word IDLE_WORD = '{op: BRANCH, rd: '0, rs1: '0, rs2: '0, imm: '0};
  function automatic logic has_rd(op_t op);
    return ~op[3];
  endfunction
endpackage

// File: rtl/iq_dispatch_if.sv
// iq_dispatch_if: decode/RS/ROB handshake bundle for the instruction queue
interface iq_dispatch_if #(parameter int NUM_RS = 4, parameter int NUM_BR = 1, parameter int CW = 4);
  import tomasula_types::*;
  logic              flush;
  logic              enq_valid;
  ctl_word           enq_word;
  logic              enq_ready;
  logic              enq_ack;
  logic              rob_full;
  logic [NUM_RS-1:0] rs_empty;
  logic [NUM_BR-1:0] rsbr_empty;
  logic [NUM_RS-1:0] rs_load;
  logic [NUM_BR-1:0] rsbr_load;
  logic              rob_load;
  logic              regfile_allocate;
  ctl_word           control_o;
  logic [CW-1:0]     count;
  modport slave(input flush, enq_valid, enq_word, rob_full, rs_empty, rsbr_empty,
                output enq_ready, enq_ack, rs_load, rsbr_load, rob_load, regfile_allocate, control_o, count);
  modport master(output flush, enq_valid, enq_word, rob_full, rs_empty, rsbr_empty,
                 input enq_ready, enq_ack, rs_load, rsbr_load, rob_load, regfile_allocate, control_o, count);
endinterface

// File: rtl/iq_dispatch_rr_pick.sv
// rr_pick: circular priority search starting at ptr, one-hot grant
module rr_pick #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);
  always_comb begin
    grant = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) grant = N'(1) << ((int'(ptr) + i) % N);
  end
  assign any = |req;
endmodule

// File: rtl/iq_dispatch.sv
// iq_dispatch: circular instruction queue dispatching the head to round-robin RS/branch stations
module iq_dispatch
  import tomasula_types::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_RS = 4,
  parameter int NUM_BR = 1,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  iq_dispatch_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int PA = NUM_RS > 1 ? $clog2(NUM_RS) : 1;
  localparam int PB = NUM_BR > 1 ? $clog2(NUM_BR) : 1;
  ctl_word           mem [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [CW-1:0]     cnt;
  logic [PA-1:0]     rr_alu, alu_nxt;
  logic [PB-1:0]     rr_br, br_nxt;
  logic [NUM_RS-1:0] alu_g;
  logic [NUM_BR-1:0] br_g;
  logic              alu_any, br_any, nonempty, is_br, dispatch;
  ctl_word           hw;
  rr_pick #(.N(NUM_RS)) alu_pick (.req(q.rs_empty), .ptr(rr_alu), .grant(alu_g), .any(alu_any));
  rr_pick #(.N(NUM_BR)) br_pick (.req(q.rsbr_empty), .ptr(rr_br), .grant(br_g), .any(br_any));
  assign hw         = mem[head];
  assign nonempty   = cnt != '0;
  assign is_br      = hw.op == BRANCH;
  assign q.enq_ready = (cnt != CW'(DEPTH)) & ~rst & ~q.flush;
  assign q.enq_ack   = q.enq_valid & q.enq_ready;
  assign dispatch   = nonempty & ~q.rob_full & ~q.flush & ~rst & (is_br ? br_any : alu_any);
  assign q.rs_load   = dispatch & ~is_br ? alu_g : '0;
  assign q.rsbr_load = dispatch & is_br ? br_g : '0;
  assign q.rob_load  = dispatch;
  assign q.regfile_allocate = dispatch & ~is_br & has_rd(hw.op);
  assign q.control_o = nonempty ? hw : IDLE_WORD;
  assign q.count     = cnt;
  always_comb begin
    alu_nxt = rr_alu;
    br_nxt = rr_br;
    for (int i = 0; i < NUM_RS; i++) if (alu_g[i]) alu_nxt = PA'((i + 1) % NUM_RS);
    for (int i = 0; i < NUM_BR; i++) if (br_g[i]) br_nxt = PB'((i + 1) % NUM_BR);
  end
  always_ff @(posedge clk) if (q.enq_ack) mem[tail] <= q.enq_word;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      rr_alu <= '0;
      rr_br <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (q.enq_ack) tail <= tail + 1'b1;
      if (dispatch) head <= head + 1'b1;
      if (dispatch & ~is_br) rr_alu <= alu_nxt;
      if (dispatch & is_br) rr_br <= br_nxt;
      cnt <= cnt + CW'(q.enq_ack) - CW'(dispatch);
    end
  end
endmodule

// File: tb/tb_iq_dispatch.sv
// tb_iq_dispatch: directed checks of enqueue, round-robin dispatch, blocking and flush
module tb_iq_dispatch;
  import tomasula_types::*;
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  ctl_word w [8];
  iq_dispatch_if #(.NUM_RS(4), .NUM_BR(1), .CW(4)) bus ();
  iq_dispatch #(.DEPTH(8), .NUM_RS(4), .NUM_BR(1), .CW(4)) dut (.clk(clk), .rst(rst), .q(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic ctl_word mk(op_t op, int n);
    return '{op: op, rd: 5'(n + 1), rs1: 5'(n), rs2: 5'(n + 2), imm: 16'(16'h100 + n)};
  endfunction
  task automatic push(input ctl_word c);
    bus.enq_valid = 1;
    bus.enq_word = c;
    #1;
    chk("push_ack", bus.enq_ack, 1);
    tick();
    bus.enq_valid = 0;
  endtask
  initial begin
    rst = 1;
    bus.flush = 0;
    bus.enq_valid = 0;
    bus.enq_word = '0;
    bus.rob_full = 0;
    bus.rs_empty = 4'b0000;
    bus.rsbr_empty = 1'b0;
    tick();
    bus.enq_valid = 1;
    #1;
    chk("rst_enq_ready", bus.enq_ready, 0);
    chk("rst_enq_ack", bus.enq_ack, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_control", bus.control_o, IDLE_WORD);
    tick();
    bus.enq_valid = 0;
    rst = 0;
    #1;
    chk("idle_count", bus.count, 0);
    chk("idle_enq_ready", bus.enq_ready, 1);
    chk("idle_rs_load", bus.rs_load, 0);
    chk("idle_rob_load", bus.rob_load, 0);
    chk("idle_op", bus.control_o.op, BRANCH);
    // fill to DEPTH with no free station
    for (int i = 0; i < 8; i++) begin
      w[i] = mk(i % 2 == 1 ? OP_SUB : OP_ADD, i);
      push(w[i]);
    end
    chk("full_count", bus.count, 8);
    chk("full_enq_ready", bus.enq_ready, 0);
    bus.enq_valid = 1;
    bus.enq_word = mk(OP_OR, 9);
    #1;
    chk("full_ack", bus.enq_ack, 0);
    tick();
    bus.enq_valid = 0;
    chk("full_count_hold", bus.count, 8);
    // drain in order; grants rotate rs0..rs3 twice
    bus.rs_empty = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_word", bus.control_o, w[i]);
      chk("drain_rs_load", bus.rs_load, 4'b0001 << (i % 4));
      chk("drain_rob_load", bus.rob_load, 1);
      tick();
    end
    chk("drain_count", bus.count, 0);
    // regfile_allocate follows op[3]
    bus.rs_empty = 4'b0000;
    push(mk(OP_ADD, 1));
    push(mk(OP_ST, 2));
    push(mk(OP_XOR, 3));
    push(mk(OP_NOP, 4));
    bus.rs_empty = 4'b1111;
    #1;
    chk("rr0_load", bus.rs_load, 4'b0001);
    chk("rr0_alloc", bus.regfile_allocate, 1);
    tick();
    chk("rr1_load", bus.rs_load, 4'b0010);
    chk("rr1_alloc", bus.regfile_allocate, 0);
    tick();
    chk("rr2_load", bus.rs_load, 4'b0100);
    chk("rr2_alloc", bus.regfile_allocate, 1);
    tick();
    chk("rr3_load", bus.rs_load, 4'b1000);
    chk("rr3_alloc", bus.regfile_allocate, 0);
    chk("rr3_rob", bus.rob_load, 1);
    tick();
    chk("rr_count", bus.count, 0);
    // branch head blocks ALU entry behind it; enqueue into empty queue does not bypass
    bus.enq_valid = 1;
    bus.enq_word = mk(BRANCH, 5);
    #1;
    chk("nobypass_rob", bus.rob_load, 0);
    tick();
    bus.enq_word = mk(OP_AND, 6);
    #1;
    chk("hol_rob", bus.rob_load, 0);
    chk("hol_rs", bus.rs_load, 0);
    tick();
    bus.enq_valid = 0;
    chk("hol_count", bus.count, 2);
    bus.rsbr_empty = 1'b1;
    #1;
    chk("br_load", bus.rsbr_load, 1);
    chk("br_rob", bus.rob_load, 1);
    chk("br_alloc", bus.regfile_allocate, 0);
    chk("br_rs", bus.rs_load, 0);
    tick();
    bus.rob_full = 1;
    #1;
    chk("robfull_rob", bus.rob_load, 0);
    chk("robfull_rs", bus.rs_load, 0);
    chk("robfull_word", bus.control_o, mk(OP_AND, 6));
    tick();
    chk("robfull_count", bus.count, 1);
    bus.rob_full = 0;
    #1;
    chk("robfree_rs", bus.rs_load, 4'b0001);
    chk("robfree_rob", bus.rob_load, 1);
    tick();
    chk("robfree_count", bus.count, 0);
    // flush at count 5 with enqueue offered and stations free
    bus.rs_empty = 4'b0000;
    for (int i = 0; i < 5; i++) push(mk(OP_SLL, i));
    chk("preflush_count", bus.count, 5);
    bus.rs_empty = 4'b1111;
    bus.flush = 1;
    bus.enq_valid = 1;
    bus.enq_word = mk(OP_SRL, 7);
    #1;
    chk("flush_ack", bus.enq_ack, 0);
    chk("flush_rob", bus.rob_load, 0);
    chk("flush_rs", bus.rs_load, 0);
    tick();
    bus.flush = 0;
    bus.enq_valid = 0;
    #1;
    chk("postflush_count", bus.count, 0);
    chk("postflush_word", bus.control_o, IDLE_WORD);
    chk("postflush_rob", bus.rob_load, 0);
    // rr_alu survived flush at 1; then wrap from ptr 2 to the only free station rs0
    bus.rs_empty = 4'b0000;
    push(mk(OP_ADD, 2));
    push(mk(OP_SUB, 3));
    bus.rs_empty = 4'b1111;
    #1;
    chk("rrkeep_rs", bus.rs_load, 4'b0010);
    tick();
    bus.rs_empty = 4'b0001;
    #1;
    chk("rrwrap_rs", bus.rs_load, 4'b0001);
    chk("rrwrap_word", bus.control_o, mk(OP_SUB, 3));
    tick();
    chk("end_count", bus.count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
